// File: rtl/rs_dispatch_pkg.sv
// Shared types and sizing helpers for the reservation-station pool.
package rs_dispatch_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_READY    = 2'd1,
    ST_WAIT_MEM = 2'd2
  } st_e;

  // Uop MSB marks a load.
  function automatic int load_bit(input int uop_w);
    return uop_w - 1;
  endfunction

  function automatic int tag_w(input int channels);
    return ($clog2(channels) > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rs_channel.sv
// One reservation station: uop slots, slot index, remaining count and temp word.
module rs_channel
  import rs_dispatch_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int UOP_W  = 20,
  parameter int DATA_W = 16,
  parameter int CNT_W  = 2
) (
  input  logic                   clk,
  input  logic                   a_rst,
  input  logic                   feed_wr_i,
  input  logic [UOP_W*DEPTH-1:0] feed_uops_i,
  input  logic [CNT_W-1:0]       feed_cnt_i,
  input  logic [DATA_W-1:0]      feed_k16_i,
  input  logic                   mem_wr_i,
  input  logic [DATA_W-1:0]      mem_data_i,
  input  logic                   issue_ack_i,
  output logic                   empty_o,
  output logic                   eligible_o,
  output logic                   wait_mem_o,
  output logic [UOP_W-1:0]       uop_o,
  output logic                   last_o,
  output logic [DATA_W-1:0]      t16_o
);

  localparam int LB = load_bit(UOP_W);

  st_e                   state_q;
  logic [CNT_W-1:0]      idx_q;
  logic [CNT_W-1:0]      rem_q;
  logic [UOP_W*DEPTH-1:0] slots_q;
  logic [DATA_W-1:0]     t16_q;

  assign empty_o    = (state_q == ST_EMPTY);
  assign eligible_o = (state_q == ST_READY);
  assign wait_mem_o = (state_q == ST_WAIT_MEM);
  assign last_o     = (rem_q == CNT_W'(1));
  assign t16_o      = t16_q;

  always_comb begin
    uop_o = '0;
    for (int s = 0; s < DEPTH; s++) begin
      if (idx_q == CNT_W'(s)) uop_o = slots_q[s*UOP_W +: UOP_W];
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (feed_wr_i) begin
            idx_q <= '0;
            rem_q <= feed_cnt_i;
            if (feed_cnt_i != '0) state_q <= ST_READY;
          end
        end
        ST_READY: begin
          if (issue_ack_i) begin
            idx_q <= idx_q + 1'b1;
            rem_q <= rem_q - 1'b1;
            // A load parks the station even when it was the final uop.
            if (uop_o[LB])                   state_q <= ST_WAIT_MEM;
            else if (rem_q == CNT_W'(1))     state_q <= ST_EMPTY;
          end
        end
        ST_WAIT_MEM: begin
          if (mem_wr_i) state_q <= (rem_q == '0) ? ST_EMPTY : ST_READY;
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (feed_wr_i && state_q == ST_EMPTY) begin
      slots_q <= feed_uops_i;
      t16_q   <= feed_k16_i;
    end else if (mem_wr_i && state_q == ST_WAIT_MEM) begin
      t16_q <= mem_data_i;
    end
  end

endmodule

// File: rtl/rs_dispatch.sv
// Station pool: lowest-free feed allocation, round-robin issue, registered execute port.
module rs_dispatch
  import rs_dispatch_pkg::*;
#(
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 3,
  parameter int UOP_W    = 20,
  parameter int DATA_W   = 16,
  localparam int TAG_W   = tag_w(CHANNELS),
  localparam int CNT_W   = cnt_w(DEPTH)
) (
  input  logic                   clk,
  input  logic                   a_rst,
  input  logic                   hold,
  input  logic [UOP_W*DEPTH-1:0] id_uops,
  input  logic [CNT_W-1:0]       id_uop_count,
  input  logic [DATA_W-1:0]      id_k16,
  output logic                   de_feed_req,
  input  logic                   de_feed_ack,
  input  logic [DATA_W-1:0]      mem_data_in,
  input  logic [TAG_W-1:0]       mem_data_tag,
  input  logic                   mem_data_wr,
  output logic [UOP_W-1:0]       ex_uop,
  output logic                   ex_uop_valid,
  output logic [TAG_W-1:0]       ex_tag,
  output logic [DATA_W-1:0]      ex_t16,
  output logic                   ex_last,
  output logic                   err
);

  logic [CHANNELS-1:0] empty_w, elig_w, wait_w, last_w;
  logic [CHANNELS-1:0] feed_sel, mem_hit, ack_w;
  logic [UOP_W-1:0]    uop_w [CHANNELS];
  logic [DATA_W-1:0]   t16_w [CHANNELS];
  logic [CNT_W-1:0]    cnt_clamped;
  logic                feed_accept, win_vld, issue_fire, mem_ok, err_ev;
  logic [TAG_W-1:0]    win_idx, rr_q;
  logic [UOP_W-1:0]    win_uop;
  logic [DATA_W-1:0]   win_t16;
  logic                win_last;

  logic [UOP_W-1:0]    ex_uop_q;
  logic                ex_vld_q, ex_last_q, err_q;
  logic [TAG_W-1:0]    ex_tag_q;
  logic [DATA_W-1:0]   ex_t16_q;

  assign de_feed_req = |empty_w;
  assign feed_accept = de_feed_req & de_feed_ack;
  assign cnt_clamped = (id_uop_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : id_uop_count;

  always_comb begin
    logic found;
    found    = 1'b0;
    feed_sel = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (empty_w[c] && !found) begin
        feed_sel[c] = feed_accept;
        found       = 1'b1;
      end
    end
  end

  // Round-robin search starts at rr_q, the station after the last issuer.
  always_comb begin
    int j;
    j       = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      j = int'(rr_q) + i;
      if (j >= CHANNELS) j = j - CHANNELS;
      if (!win_vld && elig_w[j]) begin
        win_vld = 1'b1;
        win_idx = TAG_W'(j);
      end
    end
  end

  assign issue_fire = win_vld & ~hold;

  always_comb begin
    win_uop  = '0;
    win_t16  = '0;
    win_last = 1'b0;
    ack_w    = '0;
    mem_hit  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (win_idx == TAG_W'(c)) begin
        win_uop  = uop_w[c];
        win_t16  = t16_w[c];
        win_last = last_w[c];
        ack_w[c] = issue_fire;
      end
      mem_hit[c] = mem_data_wr && (mem_data_tag == TAG_W'(c));
    end
  end

  assign mem_ok = |(mem_hit & wait_w);
  assign err_ev = (de_feed_ack & ~de_feed_req) | (mem_data_wr & ~mem_ok);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    rs_channel #(
      .DEPTH (DEPTH),
      .UOP_W (UOP_W),
      .DATA_W(DATA_W),
      .CNT_W (CNT_W)
    ) u_ch (
      .clk        (clk),
      .a_rst      (a_rst),
      .feed_wr_i  (feed_sel[g]),
      .feed_uops_i(id_uops),
      .feed_cnt_i (cnt_clamped),
      .feed_k16_i (id_k16),
      .mem_wr_i   (mem_hit[g]),
      .mem_data_i (mem_data_in),
      .issue_ack_i(ack_w[g]),
      .empty_o    (empty_w[g]),
      .eligible_o (elig_w[g]),
      .wait_mem_o (wait_w[g]),
      .uop_o      (uop_w[g]),
      .last_o     (last_w[g]),
      .t16_o      (t16_w[g])
    );
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      ex_uop_q  <= '0;
      ex_vld_q  <= 1'b0;
      ex_tag_q  <= '0;
      ex_t16_q  <= '0;
      ex_last_q <= 1'b0;
      rr_q      <= '0;
      err_q     <= 1'b0;
    end else begin
      if (!hold) begin
        ex_vld_q <= win_vld;
        if (win_vld) begin
          ex_uop_q  <= win_uop;
          ex_tag_q  <= win_idx;
          ex_t16_q  <= win_t16;
          ex_last_q <= win_last;
          rr_q      <= (win_idx == TAG_W'(CHANNELS - 1)) ? '0 : win_idx + 1'b1;
        end
      end
      if (err_ev) err_q <= 1'b1;
    end
  end

  assign ex_uop       = ex_uop_q;
  assign ex_uop_valid = ex_vld_q;
  assign ex_tag       = ex_tag_q;
  assign ex_t16       = ex_t16_q;
  assign ex_last      = ex_last_q;
  assign err          = err_q;

endmodule
